// File: rtl/lookup_engine_tcam_pipe.sv
// lookup_engine_tcam_pipe: 3-stage ternary match-action lookup.
// Table entries are written in-band over the AXIS control path. Packets that
// are not addressed to this block are forwarded one cycle later.
module lookup_engine_tcam_pipe #(
  parameter int STAGE_ID             = 0,
  parameter int LOOKUP_ID            = 2,
  parameter int PHV_LEN              = 1124,
  parameter int KEY_LEN              = 197,
  parameter int ACT_LEN              = 625,
  parameter int DEPTH                = 16,
  parameter logic [ACT_LEN-1:0] DEFAULT_ACT = 'h3f,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  localparam int IDX_W               = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [KEY_LEN-1:0]                extract_key,
  input  logic                              key_valid,
  input  logic [PHV_LEN-1:0]                phv_in,
  output logic [ACT_LEN-1:0]                action,
  output logic                              action_valid,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hit_idx,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);
  localparam int DW   = C_S_AXIS_DATA_WIDTH;
  localparam int NB   = (ACT_LEN + DW - 1) / DW;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [7:0] MY_ID = 8'(((STAGE_ID % 32) * 8) + (LOOKUP_ID % 8));

  typedef enum logic [2:0] {C_IDLE, C_KEY, C_MASK, C_ACT, C_INV, C_FWD} cstate_e;

  cstate_e              state_q, state_d;
  logic [8:0]           idx_q, idx_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [NB*DW-1:0]     abuf_q, abuf_d;
  logic [KEY_LEN-1:0]   kbuf_q, kbuf_d;
  logic                 cam_we, act_we, inv_we, fwd;
  logic [7:0]           hdr_mod, hdr_idx;
  logic [3:0]           hdr_op;
  logic                 claim, in_range;

  logic [DEPTH-1:0]     ent_val_q;
  logic [KEY_LEN-1:0]   ent_key_q  [DEPTH];
  logic [KEY_LEN-1:0]   ent_mask_q [DEPTH];
  logic [ACT_LEN-1:0]   act_q      [DEPTH];

  logic                 v1_q, v2_q;
  logic [KEY_LEN-1:0]   key1_q;
  logic [PHV_LEN-1:0]   phv1_q, phv2_q;
  logic [DEPTH-1:0]     match_d, match2_q;
  logic                 found;
  logic [IDX_W-1:0]     win_idx;
  logic [ACT_LEN-1:0]   sel_act;

  logic [ACT_LEN-1:0]   action_q;
  logic                 action_valid_q, hit_q;
  logic [PHV_LEN-1:0]   phv_out_q;
  logic [IDX_W-1:0]     hit_idx_q;

  assign hdr_mod  = c_s_axis_tdata[368 +: 8];
  assign hdr_op   = c_s_axis_tdata[380 +: 4];
  assign hdr_idx  = c_s_axis_tdata[384 +: 8];
  assign claim    = (hdr_mod == MY_ID) && (hdr_op == 4'd0 || hdr_op == 4'd2 || hdr_op == 4'd4);
  assign in_range = (idx_q < 9'(DEPTH));

  // Control FSM next state, table write strobes and forwarding decision
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    abuf_d  = abuf_q;
    kbuf_d  = kbuf_q;
    cam_we  = 1'b0;
    act_we  = 1'b0;
    inv_we  = 1'b0;
    fwd     = 1'b0;
    if (c_s_axis_tvalid) begin
      unique case (state_q)
        C_IDLE: begin
          if (claim) begin
            idx_d = {1'b0, hdr_idx};
            bc_d  = '0;
            if (!c_s_axis_tlast) begin
              if (hdr_op == 4'd0)      state_d = C_KEY;
              else if (hdr_op == 4'd2) state_d = C_ACT;
              else                     state_d = C_INV;
            end
          end else begin
            fwd = 1'b1;
            if (!c_s_axis_tlast) state_d = C_FWD;
          end
        end
        C_FWD: begin
          fwd = 1'b1;
          if (c_s_axis_tlast) state_d = C_IDLE;
        end
        C_KEY: begin
          kbuf_d  = c_s_axis_tdata[KEY_LEN-1:0];
          state_d = c_s_axis_tlast ? C_IDLE : C_MASK;
        end
        C_MASK: begin
          cam_we = in_range;
          if (c_s_axis_tlast) begin
            state_d = C_IDLE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = C_KEY;
          end
        end
        C_ACT: begin
          for (int unsigned n = 0; n < NB; n++) begin
            if (bc_q == BC_W'(n)) abuf_d[n*DW +: DW] = c_s_axis_tdata;
          end
          if (bc_q == BC_W'(NB - 1)) begin
            act_we = in_range;
            if (c_s_axis_tlast) begin
              state_d = C_IDLE;
            end else begin
              idx_d = idx_q + 9'd1;
              bc_d  = '0;
            end
          end else if (c_s_axis_tlast) begin
            state_d = C_IDLE;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
        C_INV: begin
          inv_we = in_range;
          idx_d  = idx_q + 9'd1;
          if (c_s_axis_tlast) state_d = C_IDLE;
        end
        default: state_d = C_IDLE;
      endcase
    end
  end

  // Control FSM state, entry index, beat counter and payload buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      idx_q   <= '0;
      bc_q    <= '0;
      abuf_q  <= '0;
      kbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      abuf_q  <= abuf_d;
      kbuf_q  <= kbuf_d;
    end
  end

  // Table storage; writes commit at the edge ending the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_val_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_key_q[i]  <= '0;
        ent_mask_q[i] <= '0;
        act_q[i]      <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (idx_q == 9'(i)) begin
          if (cam_we) begin
            ent_key_q[i]  <= kbuf_q;
            ent_mask_q[i] <= c_s_axis_tdata[KEY_LEN-1:0];
            ent_val_q[i]  <= 1'b1;
          end
          if (inv_we) ent_val_q[i] <= 1'b0;
          if (act_we) act_q[i] <= abuf_d[ACT_LEN-1:0];
        end
      end
    end
  end

  // S2 ternary compare against the current table contents
  always_comb begin
    match_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_d[i] = ent_val_q[i] && (((key1_q ^ ent_key_q[i]) & ~ent_mask_q[i]) == '0);
    end
  end

  // S3 priority encode, lowest index wins
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sel_act = DEFAULT_ACT;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (match2_q[i] && !found) begin
        found   = 1'b1;
        win_idx = IDX_W'(i);
        sel_act = act_q[i];
      end
    end
  end

  // Lookup pipeline registers S1/S2 and held result registers S3
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      key1_q         <= '0;
      phv1_q         <= '0;
      phv2_q         <= '0;
      match2_q       <= '0;
      action_valid_q <= 1'b0;
      action_q       <= '0;
      hit_q          <= 1'b0;
      hit_idx_q      <= '0;
      phv_out_q      <= '0;
    end else begin
      v1_q           <= key_valid;
      key1_q         <= extract_key;
      phv1_q         <= phv_in;
      v2_q           <= v1_q;
      phv2_q         <= phv1_q;
      match2_q       <= match_d;
      action_valid_q <= v2_q;
      if (v2_q) begin
        action_q  <= sel_act;
        hit_q     <= found;
        hit_idx_q <= win_idx;
        phv_out_q <= phv2_q;
      end
    end
  end

  // Forwarded control beats leave one cycle after they arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd;
      c_m_axis_tdata  <= c_s_axis_tdata;
      c_m_axis_tuser  <= c_s_axis_tuser;
      c_m_axis_tkeep  <= c_s_axis_tkeep;
      c_m_axis_tlast  <= c_s_axis_tlast;
    end
  end

  assign action       = action_q;
  assign action_valid = action_valid_q;
  assign hit          = hit_q;
  assign hit_idx      = hit_idx_q;
  assign phv_out      = phv_out_q;

endmodule

// File: tb/tb_lookup_engine_tcam_pipe.sv
// tb_lookup_engine_tcam_pipe: directed bench with a table-level reference model.
module tb_lookup_engine_tcam_pipe;
  localparam int PHV_LEN = 1124;
  localparam int KEY_LEN = 197;
  localparam int ACT_LEN = 625;
  localparam int DEPTH   = 16;
  localparam int IDX_W   = 4;
  localparam int DW      = 512;
  localparam int UW      = 128;
  localparam int KW      = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [KEY_LEN-1:0] extract_key;
  logic               key_valid;
  logic [PHV_LEN-1:0] phv_in;
  logic [ACT_LEN-1:0] action;
  logic               action_valid;
  logic [PHV_LEN-1:0] phv_out;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [DW-1:0]      c_s_axis_tdata, c_m_axis_tdata;
  logic [UW-1:0]      c_s_axis_tuser, c_m_axis_tuser;
  logic [KW-1:0]      c_s_axis_tkeep, c_m_axis_tkeep;
  logic               c_s_axis_tvalid, c_s_axis_tlast, c_m_axis_tvalid, c_m_axis_tlast;

  lookup_engine_tcam_pipe #(
    .STAGE_ID(0), .LOOKUP_ID(2), .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
    .DEPTH(DEPTH), .DEFAULT_ACT('h3f), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst), .extract_key(extract_key), .key_valid(key_valid), .phv_in(phv_in),
    .action(action), .action_valid(action_valid), .phv_out(phv_out), .hit(hit), .hit_idx(hit_idx),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser), .c_s_axis_tkeep(c_s_axis_tkeep),
    .c_s_axis_tvalid(c_s_axis_tvalid), .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser), .c_m_axis_tkeep(c_m_axis_tkeep),
    .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [PHV_LEN-1:0] got, logic [PHV_LEN-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, got[127:0], want[127:0]);
    end
  endfunction

  // Reference table
  logic [KEY_LEN-1:0] m_key  [DEPTH];
  logic [KEY_LEN-1:0] m_mask [DEPTH];
  bit                 m_val  [DEPTH];
  logic [ACT_LEN-1:0] m_act  [DEPTH];

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_key[i] = '0; m_mask[i] = '0; m_val[i] = 1'b0; m_act[i] = '0;
    end
  endfunction

  // Scan from the top so the last hit recorded is the lowest index
  function automatic void model_lookup(input logic [KEY_LEN-1:0] k, output bit h,
                                       output int unsigned ix, output logic [ACT_LEN-1:0] a);
    h = 1'b0; ix = 0; a = ACT_LEN'('h3f);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_val[i] && (((k ^ m_key[i]) & ~m_mask[i]) == '0)) begin
        h = 1'b1; ix = i; a = m_act[i];
      end
    end
  endfunction

  typedef struct {
    int unsigned        due;
    logic [ACT_LEN-1:0] act;
    bit                 hit;
    logic [IDX_W-1:0]   idx;
    logic [PHV_LEN-1:0] phv;
  } res_t;

  typedef struct {
    int unsigned due;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    bit            l;
  } bt_t;

  res_t rq[$];
  bt_t  bq[$];
  res_t r;
  bt_t  b2;
  logic [ACT_LEN-1:0] l_act;
  bit                 l_hit;
  logic [IDX_W-1:0]   l_idx;
  logic [PHV_LEN-1:0] l_phv;

  // Every cycle: either a due result/beat is present or outputs are idle and held
  always @(negedge clk) begin
    if (chk_en) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        check("action_valid", action_valid, 1);
        check("action", action, r.act);
        check("hit", hit, r.hit);
        check("hit_idx", hit_idx, r.idx);
        check("phv_out", phv_out, r.phv);
        l_act = r.act; l_hit = r.hit; l_idx = r.idx; l_phv = r.phv;
      end else begin
        check("action_valid_idle", action_valid, 0);
        check("action_hold", action, l_act);
        check("hit_hold", hit, l_hit);
        check("hit_idx_hold", hit_idx, l_idx);
        check("phv_hold", phv_out, l_phv);
      end
      if (bq.size() > 0 && bq[0].due == cyc) begin
        b2 = bq.pop_front();
        check("m_tvalid", c_m_axis_tvalid, 1);
        check("m_tdata", c_m_axis_tdata, b2.d);
        check("m_tuser", c_m_axis_tuser, b2.u);
        check("m_tkeep", c_m_axis_tkeep, b2.k);
        check("m_tlast", c_m_axis_tlast, b2.l);
      end else begin
        check("m_tvalid_idle", c_m_axis_tvalid, 0);
      end
    end
  end

  function automatic logic [PHV_LEN-1:0] rnd();
    logic [1151:0] t;
    for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
    return t[PHV_LEN-1:0];
  endfunction

  function automatic logic [DW-1:0] hdr(logic [7:0] mid, logic [3:0] op, logic [7:0] idx);
    logic [DW-1:0] d;
    d = '0;
    d[368 +: 8] = mid;
    d[380 +: 4] = op;
    d[384 +: 8] = idx;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last, input bit fwd);
    bt_t b;
    c_s_axis_tdata  = d;
    c_s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    c_s_axis_tkeep  = {$urandom, $urandom};
    c_s_axis_tvalid = 1'b1;
    c_s_axis_tlast  = last;
    if (fwd) begin
      b.due = cyc + 1; b.d = d; b.u = c_s_axis_tuser; b.k = c_s_axis_tkeep; b.l = last;
      bq.push_back(b);
    end
    @(posedge clk); #1;
    c_s_axis_tvalid = 1'b0;
    c_s_axis_tlast  = 1'b0;
  endtask

  task automatic cam_pkt(input int idx, input int n, input logic [KEY_LEN-1:0] k0, m0, k1, m1);
    beat(hdr(8'h02, 4'd0, 8'(idx)), 1'b0, 1'b0);
    for (int j = 0; j < n; j++) begin
      logic [KEY_LEN-1:0] kk, mm;
      kk = (j == 0) ? k0 : k1;
      mm = (j == 0) ? m0 : m1;
      beat(DW'(kk), 1'b0, 1'b0);
      if (j == 0) idle(1);
      beat(DW'(mm), j == n - 1, 1'b0);
      if (idx + j < DEPTH) begin
        m_key[idx+j] = kk; m_mask[idx+j] = mm; m_val[idx+j] = 1'b1;
      end
    end
  endtask

  task automatic act_pkt(input int idx, input logic [ACT_LEN-1:0] a);
    beat(hdr(8'h02, 4'd2, 8'(idx)), 1'b0, 1'b0);
    beat(a[DW-1:0], 1'b0, 1'b0);
    beat(DW'(a[ACT_LEN-1:DW]), 1'b1, 1'b0);
    if (idx < DEPTH) m_act[idx] = a;
  endtask

  task automatic inv_pkt(input int idx, input int n);
    beat(hdr(8'h02, 4'd4, 8'(idx)), 1'b0, 1'b0);
    for (int j = 0; j < n; j++) begin
      beat('0, j == n - 1, 1'b0);
      if (idx + j < DEPTH) m_val[idx+j] = 1'b0;
    end
  endtask

  // exp_idx < 0 means a miss is expected; pins the model against hand-derived results
  task automatic lookup(input logic [KEY_LEN-1:0] k, input int exp_idx, input logic [ACT_LEN-1:0] exp_act);
    res_t e;
    bit h;
    int unsigned ix;
    logic [ACT_LEN-1:0] a;
    logic [PHV_LEN-1:0] p;
    p = rnd();
    model_lookup(k, h, ix, a);
    check("pin_hit", h, exp_idx >= 0);
    check("pin_idx", ix, (exp_idx >= 0) ? exp_idx : 0);
    check("pin_act", a, exp_act);
    e.due = cyc + 3; e.act = a; e.hit = h; e.idx = IDX_W'(ix); e.phv = p;
    rq.push_back(e);
    extract_key = k; phv_in = p; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  logic [PHV_LEN-1:0] tmp;
  logic [KEY_LEN-1:0] K, K1, E5, E6, E7, E8, mk;
  logic [ACT_LEN-1:0] A, B, DEF;
  logic [DW-1:0]      w0, w1;

  initial begin
    rst = 1'b1; key_valid = 1'b0; extract_key = '0; phv_in = '0;
    c_s_axis_tdata = '0; c_s_axis_tuser = '0; c_s_axis_tkeep = '0;
    c_s_axis_tvalid = 1'b0; c_s_axis_tlast = 1'b0;
    l_act = '0; l_hit = 1'b0; l_idx = '0; l_phv = '0;
    model_clear();
    DEF = ACT_LEN'('h3f);
    tmp = rnd(); K  = tmp[KEY_LEN-1:0]; K[0]  = 1'b0;
    K1 = K; K1[0] = 1'b1;
    tmp = rnd(); E5 = tmp[KEY_LEN-1:0]; E5[0] = 1'b1;
    tmp = rnd(); E6 = tmp[KEY_LEN-1:0]; E6[0] = 1'b1;
    tmp = rnd(); E7 = tmp[KEY_LEN-1:0]; E7[0] = 1'b1;
    tmp = rnd(); E8 = tmp[KEY_LEN-1:0]; E8[0] = 1'b1;
    tmp = rnd(); A  = tmp[ACT_LEN-1:0];
    tmp = rnd(); B  = tmp[ACT_LEN-1:0];
    tmp = rnd(); w0 = tmp[DW-1:0];
    tmp = rnd(); w1 = tmp[DW-1:0];
    mk = '1; mk[0] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_action_valid", action_valid, 0);
    check("rst_action", action, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_idx", hit_idx, 0);
    check("rst_phv_out", phv_out, 0);
    check("rst_m_tvalid", c_m_axis_tvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // 1: empty table, back-to-back misses
    for (int i = 0; i < 8; i++) begin
      tmp = rnd();
      lookup(tmp[KEY_LEN-1:0], -1, DEF);
    end
    idle(4);

    // 2: exact entry 3 with its action
    cam_pkt(3, 1, K, '0, '0, '0);
    act_pkt(3, A);
    lookup(K, 3, A);
    idle(4);

    // 3: lower index wins; entry 3 made bit0 don't-care
    cam_pkt(1, 1, '0, mk, '0, '0);
    cam_pkt(3, 1, K, KEY_LEN'(1), '0, '0);
    lookup(K, 1, '0);
    lookup(K1, 3, A);
    idle(4);

    // 4: two entries in one packet, invalidate the first; top-index boundary
    cam_pkt(5, 2, E5, '0, E6, '0);
    inv_pkt(5, 1);
    lookup(E6, 6, '0);
    lookup(E5, -1, DEF);
    cam_pkt(15, 2, E7, '0, E8, '0);
    lookup(E7, 15, '0);
    lookup(E8, -1, DEF);
    idle(4);

    // 5: foreign and unsupported-op packets pass through during lookups
    fork
      begin
        beat(hdr(8'h0A, 4'd0, 8'd3), 1'b0, 1'b1);
        beat(DW'(E5), 1'b0, 1'b1);
        idle(1);
        beat(w0, 1'b0, 1'b1);
        beat(w1, 1'b1, 1'b1);
        beat(hdr(8'h02, 4'd1, 8'd3), 1'b0, 1'b1);
        beat(w0, 1'b1, 1'b1);
      end
      begin
        lookup(K, 1, '0);
        lookup(K1, 3, A);
        lookup(E6, 6, '0);
        lookup(E5, -1, DEF);
        lookup(E7, 15, '0);
        lookup(K1, 3, A);
      end
    join
    lookup(K1, 3, A);
    lookup(E5, -1, DEF);
    idle(6);

    // 6: reset in the middle of an action packet
    beat(hdr(8'h02, 4'd2, 8'd3), 1'b0, 1'b0);
    beat(B[DW-1:0], 1'b0, 1'b0);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2_action_valid", action_valid, 0);
    check("rst2_action", action, 0);
    check("rst2_hit", hit, 0);
    check("rst2_hit_idx", hit_idx, 0);
    check("rst2_phv_out", phv_out, 0);
    check("rst2_m_tvalid", c_m_axis_tvalid, 0);
    check("rst2_m_tdata", c_m_axis_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    rq.delete(); bq.delete();
    l_act = '0; l_hit = 1'b0; l_idx = '0; l_phv = '0;
    chk_en = 1'b1;
    idle(1);
    cam_pkt(2, 1, E6, '0, '0, '0);
    act_pkt(2, B);
    lookup(E6, 2, B);
    lookup(K, -1, DEF);
    lookup(K1, -1, DEF);

    repeat (6) begin @(posedge clk); #1; end
    check("drain_results", rq.size(), 0);
    check("drain_beats", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
